// File: rtl/cla_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : cla_adder_pipe
// Function : Pipelined carry-lookahead adder/subtractor. The carry chain is
//            cut into BLOCK-bit lookahead groups, and the groups are spread
//            over STAGES register stages with a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module cla_adder_pipe #(
    parameter int WIDTH  = 64,
    parameter int BLOCK  = 4,
    parameter int STAGES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    input  logic                     ci,
    input  logic                     op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         s,
    output logic                     co,
    output logic                     ovf,
    output logic [WIDTH/BLOCK-1:0]   c
);

    localparam int c_NG   = WIDTH / BLOCK;    // number of lookahead groups
    localparam int c_GPS  = c_NG / STAGES;    // groups resolved per stage
    localparam int c_LAST = STAGES - 1;

    // Per-stage registers. Operands travel with the beat; only the bits of
    // groups not yet resolved are read downstream, the rest is pruned away.
    logic [STAGES-1:0] r_vld;
    logic [WIDTH-1:0]  r_a  [STAGES];
    logic [WIDTH-1:0]  r_be [STAGES];
    logic [WIDTH-1:0]  r_s  [STAGES];
    logic [c_NG-1:0]   r_c  [STAGES];

    // Stage inputs (from ports for stage 0, from the previous stage otherwise)
    logic [WIDTH-1:0]  w_a_in  [STAGES];
    logic [WIDTH-1:0]  w_be_in [STAGES];
    logic [WIDTH-1:0]  w_s_in  [STAGES];
    logic [c_NG-1:0]   w_c_in  [STAGES];
    logic [STAGES-1:0] w_cin;
    logic [STAGES-1:0] w_v_in;

    // Stage results with this stage's groups filled in
    logic [WIDTH-1:0]  w_s_nx [STAGES];
    logic [c_NG-1:0]   w_c_nx [STAGES];

    // Stage k may load a new beat this cycle
    logic [STAGES-1:0] w_ld;

    // One lookahead group: every internal carry is a flat generate/propagate
    // product term of the group carry-in, so the group carry-out is G | P&cin.
    function automatic logic [BLOCK:0] f_group(
        input logic [BLOCK-1:0] x,
        input logic [BLOCK-1:0] y,
        input logic             cin
    );
        logic [BLOCK-1:0] p;
        logic [BLOCK-1:0] g;
        logic [BLOCK:0]   cy;
        logic             t;
        p     = x ^ y;
        g     = x & y;
        cy    = '0;
        cy[0] = cin;
        for (int j = 1; j <= BLOCK; j++) begin
            t = cin;
            for (int m = 0; m < j; m++) t = t & p[m];
            cy[j] = t;
            for (int m = 0; m < j; m++) begin
                t = g[m];
                for (int n = m + 1; n < j; n++) t = t & p[n];
                cy[j] = cy[j] | t;
            end
        end
        return {cy[BLOCK], p ^ cy[BLOCK-1:0]};
    endfunction

    // Load enables ripple from the output back: a stage loads when it is
    // empty or its successor is loading, so bubbles collapse under a stall.
    always_comb begin
        w_ld         = '0;
        w_ld[c_LAST] = out_ready || !r_vld[c_LAST];
        for (int k = c_LAST - 1; k >= 0; k--) begin
            w_ld[k] = !r_vld[k] || w_ld[k+1];
        end
    end

    assign in_ready = rst_n && w_ld[0];

    // Select each stage's source; subtraction inverts B and flips the carry-in.
    always_comb begin
        w_a_in  = '{default: '0};
        w_be_in = '{default: '0};
        w_s_in  = '{default: '0};
        w_c_in  = '{default: '0};
        w_cin   = '0;
        w_v_in  = '0;
        w_a_in[0]  = a;
        w_be_in[0] = op ? ~b : b;
        w_cin[0]   = ci ^ op;
        w_v_in[0]  = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            w_a_in[k]  = r_a[k-1];
            w_be_in[k] = r_be[k-1];
            w_s_in[k]  = r_s[k-1];
            w_c_in[k]  = r_c[k-1];
            w_cin[k]   = r_c[k-1][k*c_GPS-1];
            w_v_in[k]  = r_vld[k-1];
        end
    end

    // Resolve this stage's groups, rippling group carries between them.
    always_comb begin
        logic [BLOCK:0] w_grp;
        logic           w_cy;
        w_s_nx = '{default: '0};
        w_c_nx = '{default: '0};
        w_grp  = '0;
        w_cy   = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            w_s_nx[k] = w_s_in[k];
            w_c_nx[k] = w_c_in[k];
            w_cy      = w_cin[k];
            for (int gi = 0; gi < c_GPS; gi++) begin
                w_grp = f_group(w_a_in[k][(k*c_GPS+gi)*BLOCK +: BLOCK],
                                w_be_in[k][(k*c_GPS+gi)*BLOCK +: BLOCK],
                                w_cy);
                w_s_nx[k][(k*c_GPS+gi)*BLOCK +: BLOCK] = w_grp[BLOCK-1:0];
                w_c_nx[k][k*c_GPS+gi]                  = w_grp[BLOCK];
                w_cy                                   = w_grp[BLOCK];
            end
        end
    end

    // Pipeline registers: valid moves on every load, data only with a real beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_a[k]  <= '0;
                r_be[k] <= '0;
                r_s[k]  <= '0;
                r_c[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_ld[k]) begin
                    r_vld[k] <= w_v_in[k];
                    if (w_v_in[k]) begin
                        r_a[k]  <= w_a_in[k];
                        r_be[k] <= w_be_in[k];
                        r_s[k]  <= w_s_nx[k];
                        r_c[k]  <= w_c_nx[k];
                    end
                end
            end
        end
    end

    assign out_valid = r_vld[c_LAST];
    assign s         = r_s[c_LAST];
    assign c         = r_c[c_LAST];
    assign co        = r_c[c_LAST][c_NG-1];
    assign ovf       = (r_a[c_LAST][WIDTH-1] == r_be[c_LAST][WIDTH-1]) &&
                       (r_s[c_LAST][WIDTH-1] != r_a[c_LAST][WIDTH-1]);

endmodule
`default_nettype wire

// File: tb/tb_cla_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_adder_pipe
// Function : Self-checking bench for cla_adder_pipe (64/4/4). Expected
//            results come from plain wide arithmetic kept in a queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cla_adder_pipe;

    localparam int W  = 64;
    localparam int NG = 16;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          ci;
    logic          op;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  s;
    logic          co;
    logic          ovf;
    logic [NG-1:0] c;

    cla_adder_pipe #(.WIDTH(W), .BLOCK(4), .STAGES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci), .op(op), .out_valid(out_valid),
        .out_ready(out_ready), .s(s), .co(co), .ovf(ovf), .c(c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  s;
        logic          co;
        logic          ovf;
        logic [NG-1:0] c;
        int            acc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    bit   lat_chk = 1'b1;
    bit   prev_stall = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: whole-word arithmetic; group carries from prefix-width sums;
    // overflow from the true signed sum leaving the 64-bit range.
    function automatic exp_t model(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                   input logic cc, input logic oo, input int cy);
        exp_t              e;
        logic [W-1:0]      be;
        logic              cin;
        logic [W:0]        full;
        logic [W:0]        m;
        logic [W:0]        part;
        logic signed [W+1:0] t;
        be     = oo ? ~bb : bb;
        cin    = cc ^ oo;
        full   = {1'b0, aa} + {1'b0, be} + {{W{1'b0}}, cin};
        e.s    = full[W-1:0];
        e.co   = full[W];
        t      = $signed({{2{aa[W-1]}}, aa}) + $signed({{2{be[W-1]}}, be}) +
                 $signed({{(W+1){1'b0}}, cin});
        e.ovf  = (t > $signed({2'b00, {(W-1){1'b1}}, 1'b1} >>> 1)) ||
                 (t < -$signed({2'b00, 1'b1, {(W-1){1'b0}}}));
        e.c    = '0;
        for (int g = 0; g < NG; g++) begin
            m    = ({{W{1'b0}}, 1'b1} << (4 * (g + 1))) - 1;
            part = ({1'b0, aa} & m) + ({1'b0, be} & m) + {{W{1'b0}}, cin};
            e.c[g] = part[4 * (g + 1)];
        end
        e.acc = cy;
        return e;
    endfunction

    // One clock cycle: inputs were set at the preceding negedge; sample,
    // score emits/accepts, then wait for the next negedge.
    task automatic cycle(output bit acc);
        exp_t e;
        #1;
        acc = 1'b0;
        if (prev_stall) chk("hold_valid", out_valid, 1);
        if (out_valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("spurious_out", out_valid, 0);
            end else begin
                e = q[0];
                chk("s", s, e.s);
                chk("co", co, e.co);
                chk("ovf", ovf, e.ovf);
                chk("c", c, e.c);
                if (out_ready) begin
                    void'(q.pop_front());
                    if (lat_chk) chk("latency", cyc - e.acc, 4);
                end
            end
        end
        if (in_valid && in_ready === 1'b1) begin
            q.push_back(model(a, b, ci, op, cyc));
            acc = 1'b1;
        end
        prev_stall = (out_valid === 1'b1) && !out_ready;
        cyc++;
        @(negedge clk);
    endtask

    task automatic send(input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic cc, input logic oo);
        bit acc;
        int n;
        in_valid = 1'b1; a = aa; b = bb; ci = cc; op = oo;
        acc = 1'b0; n = 0;
        while (!acc && n < 50) begin
            cycle(acc);
            n++;
        end
        in_valid = 1'b0;
        chk("send_accept", acc, 1);
    endtask

    // Replace fields of the newest expectation with values stated outright.
    task automatic ovr(input bit [3:0] en, input logic [W-1:0] vs, input logic vco,
                       input logic vovf, input logic [NG-1:0] vc);
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_back();
            if (en[0]) e.s   = vs;
            if (en[1]) e.co  = vco;
            if (en[2]) e.ovf = vovf;
            if (en[3]) e.c   = vc;
            q.push_back(e);
        end
    endtask

    task automatic drain(input int maxc);
        bit acc;
        int n;
        in_valid = 1'b0; out_ready = 1'b1; n = 0;
        while (q.size() > 0 && n < maxc) begin
            cycle(acc);
            n++;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        bit acc;
        int bi;
        rst_n = 1'b1; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; op = 1'b0;
        out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_s", s, 0);
        chk("rst_c", c, 0);
        chk("rst_co_ovf", {co, ovf}, 0);
        chk("rst_in_ready", in_ready, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rel_in_ready", in_ready, 1);

        // Directed corner cases, back to back
        lat_chk = 1'b1;
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        ovr(4'b1111, 64'd0, 1'b1, 1'b0, 16'hFFFF);
        send(64'd5, 64'd7, 1'b0, 1'b1);
        ovr(4'b0111, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, '0);
        send(64'd5, 64'd7, 1'b1, 1'b1);
        ovr(4'b0001, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0, '0);
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        ovr(4'b0111, 64'h8000_0000_0000_0000, 1'b0, 1'b1, '0);
        send(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1);
        ovr(4'b0100, '0, 1'b0, 1'b1, '0);
        drain(20);

        // Streaming sweep: one beat per cycle, add grid then subtract grid
        for (int o = 0; o < 2; o++) begin
            for (int ai = 0; ai < 32; ai++) begin
                for (int bj = 0; bj < 32; bj++) begin
                    in_valid = 1'b1; a = 64'(ai); b = 64'(bj);
                    ci = 1'($urandom_range(1)); op = 1'(o);
                    cycle(acc);
                    chk("sweep_accept", acc, 1);
                end
            end
        end
        drain(20);

        // Backpressure: six beats offered against a stalled output
        lat_chk = 1'b0; out_ready = 1'b0; bi = 0;
        for (int n = 0; n < 8; n++) begin
            in_valid = (bi < 6); a = 64'(1000 + bi * 17); b = 64'(bi * 3);
            ci = 1'b0; op = bi[0];
            cycle(acc);
            if (acc) bi++;
        end
        chk("bp_accepts_4", bi, 4);
        #1 chk("bp_in_ready_low", in_ready, 0);
        out_ready = 1'b1;
        in_valid = 1'b1; a = 64'(1000 + bi * 17); b = 64'(bi * 3); op = bi[0];
        cycle(acc);
        if (acc) bi++;
        chk("bp_accepts_5", bi, 5);
        out_ready = 1'b0;
        for (int n = 0; n < 4; n++) begin
            in_valid = 1'b1; a = 64'(1000 + bi * 17); b = 64'(bi * 3); op = bi[0];
            cycle(acc);
            if (acc) bi++;
        end
        chk("bp_still_5", bi, 5);
        out_ready = 1'b1;
        for (int n = 0; n < 20 && (bi < 6 || q.size() > 0); n++) begin
            in_valid = (bi < 6); a = 64'(1000 + bi * 17); b = 64'(bi * 3); op = bi[0];
            cycle(acc);
            if (acc) bi++;
        end
        in_valid = 1'b0;
        chk("bp_all_sent", bi, 6);
        chk("bp_all_recv", q.size(), 0);

        // Randomised traffic with random backpressure
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(3) != 0);
            a         = {$urandom, $urandom};
            b         = {$urandom, $urandom};
            ci        = 1'($urandom_range(1));
            op        = 1'($urandom_range(1));
            out_ready = ($urandom_range(2) != 0);
            cycle(acc);
        end
        drain(40);

        // Reset with beats in flight
        out_ready = 1'b0;
        for (int n = 0; n < 3; n++) send(64'(100 + n), 64'(n), 1'b0, 1'b0);
        for (int n = 0; n < 3; n++) cycle(acc);
        #1 chk("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_s", s, 0);
        chk("mid_rst_c", c, 0);
        chk("mid_rst_co_ovf", {co, ovf}, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        #1 chk("post_rst_in_ready", in_ready, 1);
        q.delete();
        prev_stall = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 6; n++) begin
            cycle(acc);
            chk("no_stale", out_valid, 0);
        end
        lat_chk = 1'b1;
        send(64'd3, 64'd4, 1'b0, 1'b0);
        ovr(4'b0001, 64'd7, 1'b0, 1'b0, '0);
        drain(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
